// File: rtl/sound_mixer_seq_pkg.sv
// Shared definitions for the sound blocks: mixer FSM encoding and a
// constant-evaluable clog2 used to size counters and pointers.
package sound_mixer_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SCALE,
        ST_PUSH
    } mix_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sound_mixer_seq_if.sv
// Output sample stream of the mixer: valid/ready with a stereo payload.
interface sound_mixer_seq_if #(
    parameter int OUT_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_left;
    logic [OUT_W-1:0] out_right;

    modport master (
        output out_valid,
        output out_left,
        output out_right,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_left,
        input  out_right,
        output out_ready
    );
endinterface

// File: rtl/sound_mixer_seq_fifo.sv
// First-word-fall-through FIFO with occupancy count and flush.
// Storage is not reset; the head reads as zero while empty.
module sound_fifo
    import sound_mixer_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [clog2(DEPTH):0]    o_count
);
    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CW = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = i_pop && !w_empty && !i_flush;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_push  = i_push && !i_flush && (!o_full || w_pop);
    assign o_valid = !w_empty;
    assign o_count = r_cnt;
    assign o_rdata = w_empty ? '0 : r_mem[r_rd];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
        end
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_wdata;
    end
endmodule

// File: rtl/sound_mixer_seq.sv
// Sequential stereo mixer: one channel per cycle, master volume scale,
// then a push into a small output FIFO.
module sound_mixer_seq
    import sound_mixer_seq_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int LEVEL_W    = 4,
    parameter int VOL_W      = 3,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      sample_tick,
    input  logic [NUM_CH*LEVEL_W-1:0] ch_level,
    input  logic [NUM_CH-1:0]         pan_left,
    input  logic [NUM_CH-1:0]         pan_right,
    input  logic [VOL_W-1:0]          vol_left,
    input  logic [VOL_W-1:0]          vol_right,
    input  logic                      clear_flags,
    sound_mixer_seq_if.master         out_if,
    output logic                      busy,
    output logic                      tick_missed,
    output logic                      sample_dropped,
    output logic [clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CLG   = clog2(NUM_CH);
    localparam int IDX_W = (CLG < 1) ? 1 : CLG;
    localparam int ACC_W = LEVEL_W + IDX_W;
    localparam int SCL_W = ACC_W + VOL_W;
    localparam int PAD   = OUT_W - 1 - SCL_W;

    mix_state_t                r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [NUM_CH*LEVEL_W-1:0] r_level;
    logic [NUM_CH-1:0]         r_pan_l;
    logic [NUM_CH-1:0]         r_pan_r;
    logic [VOL_W-1:0]          r_vol_l;
    logic [VOL_W-1:0]          r_vol_r;
    logic [ACC_W-1:0]          r_acc_l;
    logic [ACC_W-1:0]          r_acc_r;
    logic [SCL_W-1:0]          r_scl_l;
    logic [SCL_W-1:0]          r_scl_r;

    logic [LEVEL_W-1:0]        w_lvl;
    logic [VOL_W:0]            w_vp1_l;
    logic [VOL_W:0]            w_vp1_r;
    logic [OUT_W-1:0]          w_out_l;
    logic [OUT_W-1:0]          w_out_r;
    logic [2*OUT_W-1:0]        w_rdata;
    logic                      w_push;
    logic                      w_full;
    logic                      w_drop;

    assign busy    = (r_state != ST_IDLE);
    assign w_vp1_l = {1'b0, r_vol_l} + (VOL_W+1)'(1);
    assign w_vp1_r = {1'b0, r_vol_r} + (VOL_W+1)'(1);
    assign w_out_l = OUT_W'(r_scl_l) << PAD;
    assign w_out_r = OUT_W'(r_scl_r) << PAD;
    assign w_push  = enable && (r_state == ST_PUSH);
    assign w_drop  = w_push && w_full && !out_if.out_ready;

    // Select the snapshot level of the channel being accumulated.
    always_comb begin
        w_lvl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_idx == IDX_W'(i)) w_lvl = r_level[i*LEVEL_W +: LEVEL_W];
        end
    end

    // Frame sequencer: snapshot, accumulate, scale, push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_level <= '0;
            r_pan_l <= '0;
            r_pan_r <= '0;
            r_vol_l <= '0;
            r_vol_r <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_scl_l <= '0;
            r_scl_r <= '0;
        end else if (!enable) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        r_level <= ch_level;
                        r_pan_l <= pan_left;
                        r_pan_r <= pan_right;
                        r_vol_l <= vol_left;
                        r_vol_r <= vol_right;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_idx   <= '0;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (r_pan_l[r_idx]) r_acc_l <= r_acc_l + ACC_W'(w_lvl);
                    if (r_pan_r[r_idx]) r_acc_r <= r_acc_r + ACC_W'(w_lvl);
                    if (r_idx == IDX_W'(NUM_CH - 1)) begin
                        r_state <= ST_SCALE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_SCALE: begin
                    r_scl_l <= SCL_W'(r_acc_l) * SCL_W'(w_vp1_l);
                    r_scl_r <= SCL_W'(r_acc_r) * SCL_W'(w_vp1_r);
                    r_state <= ST_PUSH;
                end
                ST_PUSH: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_missed    <= 1'b0;
            sample_dropped <= 1'b0;
        end else begin
            if (sample_tick && busy) tick_missed <= 1'b1;
            else if (clear_flags)    tick_missed <= 1'b0;
            if (w_drop)              sample_dropped <= 1'b1;
            else if (clear_flags)    sample_dropped <= 1'b0;
        end
    end

    sound_fifo #(
        .WIDTH (2*OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (!enable),
        .i_push  (w_push),
        .i_pop   (out_if.out_ready),
        .i_wdata ({w_out_l, w_out_r}),
        .o_rdata (w_rdata),
        .o_valid (out_if.out_valid),
        .o_full  (w_full),
        .o_count (fifo_count)
    );

    assign out_if.out_left  = w_rdata[2*OUT_W-1:OUT_W];
    assign out_if.out_right = w_rdata[OUT_W-1:0];
endmodule

// File: doc/sound_mixer_seq.md
SOUND_MIXER_SEQ -- requirements
Module: sound_mixer_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of channel inputs, 1..16.
REQ-002 SHALL have parameter LEVEL_W, default 4: width of each channel level.
REQ-003 SHALL have parameter VOL_W, default 3: width of each master volume.
REQ-004 SHALL have parameter OUT_W, default 16: output sample width, at least ACC_W+VOL_W+1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: output FIFO depth, a power of two no smaller than 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: mixer on; low flushes the mixer.
REQ-009 SHALL have port sample_tick, input, 1 bit: one-cycle pulse that starts a mix frame.
REQ-010 SHALL have port ch_level, input, NUM_CH*LEVEL_W bits: unsigned levels, channel i at bits [i*LEVEL_W +: LEVEL_W].
REQ-011 SHALL have ports pan_left and pan_right, input, NUM_CH bits each: per-channel routing enables.
REQ-012 SHALL have ports vol_left and vol_right, input, VOL_W bits each: master volumes.
REQ-013 SHALL have port clear_flags, input, 1 bit: clears the sticky flags.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the head sample.
REQ-015 SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-016 SHALL have ports out_left and out_right, output, OUT_W bits each: head sample, first-word-fall-through.
REQ-017 SHALL have port busy, output, 1 bit: FSM not in IDLE.
REQ-018 SHALL have ports tick_missed and sample_dropped, output, 1 bit each: sticky error flags.
REQ-019 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-020 SHALL define ACC_W = LEVEL_W + clog2(NUM_CH) (minimum LEVEL_W+1); all accumulation is unsigned and can never overflow.
REQ-021 SHALL use a FSM with states IDLE, ACCUM, SCALE and PUSH.
REQ-022 SHALL, in IDLE with enable=1 and sample_tick=1, snapshot ch_level, pan_left, pan_right, vol_left and vol_right, clear both accumulators, set index to 0 and go to ACCUM.
REQ-023 SHALL, in ACCUM, on each cycle add snapshot level[index] to the left accumulator if pan_left[index] is set and to the right accumulator if pan_right[index] is set; after index NUM_CH-1 it goes to SCALE (one channel per cycle, NUM_CH cycles).
REQ-024 SHALL, in SCALE, compute scaled = acc*(vol+1) per side, width ACC_W+VOL_W, and go to PUSH.
REQ-025 SHALL, in PUSH, write out = {1'b0, scaled, zero padding} truncated to OUT_W bits into the FIFO and return to IDLE.
REQ-026 SHALL give a latency of NUM_CH+3 clock edges from the edge sampling sample_tick to out_valid=1, with the FIFO initially empty.
REQ-027 SHALL ignore changes to inputs after the snapshot until the next frame.
REQ-028 SHALL, on sample_tick while busy=1, ignore the tick, keep the frame running and set tick_missed.
REQ-029 SHALL, when PUSH finds the FIFO full and out_ready=0, discard the sample and set sample_dropped; full with out_ready=1 on the same edge pops and pushes, and the count stays unchanged.
REQ-030 SHALL pop the FIFO on out_valid & out_ready; out_ready while empty has no effect.
REQ-031 SHALL, with clear_flags=1, clear both sticky flags; a set event in the same cycle wins.
REQ-032 SHALL, with enable=0, put the FSM in IDLE, clear the accumulators, empty the FIFO and force out_valid=0 on the next edge; sticky flags are kept.

Reset
REQ-033 SHALL, while rst=0 (asynchronous), hold FSM=IDLE, index=0, accumulators=0, FIFO empty, out_valid=0, out_left/out_right=0, busy=0, tick_missed=0, sample_dropped=0 and fifo_count=0.
REQ-034 SHALL let rst assert mid-frame, abandon the frame and push no partial sample.
REQ-035 SHALL leave FIFO storage contents unreset; only the pointers and count are reset.

Structure
REQ-036 SHALL place the FSM state encoding and a clog2 constant function in the shared sound package, where the other sound blocks use them too.
REQ-037 SHALL instantiate exactly one sub-module, sound_fifo (parametrised width/depth, FWFT, count output), holding {left, right}.

Verification
REQ-038 SHALL test all defaults with levels 15,15,15,15, all pans 1, vols 7, one tick -> out_valid after 7 edges; out_left = out_right = 0x7800.
REQ-039 SHALL test levels 1,2,3,4, pan_left=0101, pan_right=1010, vol_left=0, vol_right=1 -> left = 4<<6 = 0x0100, right = 12<<6 = 0x0300.
REQ-040 SHALL test a tick on edge 3 of a frame -> tick_missed=1, one sample only; clear_flags -> 0.
REQ-041 SHALL test out_ready=0 with 5 frames -> fifo_count=4 and sample_dropped=1; the head is the first sample.
REQ-042 SHALL test rst low during ACCUM -> all outputs 0 immediately, no sample after release; an enable drop with 2 samples queued -> out_valid=0 next edge.
REQ-043 SHALL test NUM_CH=8, LEVEL_W=4 with all levels 15 and vol 7 -> latency 11 edges, value 120*8 = 960, out = 960<<5 = 0x7800.
